// File: rtl/mod_n_slot_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_sched_pkg
//  Description : Shared types and helpers for the mod-N slot scheduler:
//                FSM state encoding and pointer-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_n_sched_pkg;

    // Scheduler states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    localparam int C_N_REQ_DEFAULT   = 4;
    localparam int C_DWELL_W_DEFAULT = 8;

    // Slot pointer width; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : mod_n_sched_pkg
`default_nettype wire

// File: rtl/mod_n_slot_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_sched_if
//  Description : Requester-side bus of the slot scheduler. The master drives
//                control, mask, dwell and requests; the slave (scheduler)
//                returns grant, pointer index, busy and frame marker.
//                The early-release input is called slot_release because
//                "release" is a reserved word in SystemVerilog.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_n_sched_if
    import mod_n_sched_pkg::*;
#(
    parameter int N_REQ   = C_N_REQ_DEFAULT,
    parameter int DWELL_W = C_DWELL_W_DEFAULT
);
    localparam int PTR_W = ptr_width(N_REQ);

    logic                start;
    logic                stop;
    logic [N_REQ-1:0]    slot_mask;
    logic [DWELL_W-1:0]  dwell;
    logic [N_REQ-1:0]    req;
    logic                slot_release;
    logic [N_REQ-1:0]    grant;
    logic [PTR_W-1:0]    grant_id;
    logic                busy;
    logic                frame_done;

    modport master (
        output start, stop, slot_mask, dwell, req, slot_release,
        input  grant, grant_id, busy, frame_done
    );

    modport slave (
        input  start, stop, slot_mask, dwell, req, slot_release,
        output grant, grant_id, busy, frame_done
    );

endinterface : mod_n_sched_if
`default_nettype wire

// File: rtl/mod_n_slot_scheduler_slot_ptr_mod_n.sv
`default_nettype none
// ============================================================================
//  Module      : slot_ptr_mod_n
//  Description : Synchronous-reset wrapping mod-N slot pointer. clr has
//                priority over inc. wrap is a registered one-cycle pulse that
//                appears together with the pointer returning to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_ptr_mod_n
    import mod_n_sched_pkg::*;
#(
    parameter int N_REQ = C_N_REQ_DEFAULT
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       clr,
    input  wire logic                       inc,
    output logic [ptr_width(N_REQ)-1:0]     ptr,
    output logic                            wrap
);
    localparam int               PTR_W  = ptr_width(N_REQ);
    // Explicit terminal compare so non-power-of-2 N_REQ never aliases.
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             wrap_q, wrap_d;

    // Next pointer value and wrap detection.
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            if (ptr_q == C_LAST) begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer and wrap registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr  = ptr_q;
    assign wrap = wrap_q;

endmodule : slot_ptr_mod_n
`default_nettype wire

// File: rtl/mod_n_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mod_n_slot_scheduler
//  Description : Time-division scheduler sharing one resource among N_REQ
//                requesters. A mod-N pointer visits each slot; an enabled,
//                requesting slot gets a one-hot grant for up to dwell cycles,
//                followed by a one-cycle break-before-make gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_n_slot_scheduler
    import mod_n_sched_pkg::*;
#(
    parameter int N_REQ   = C_N_REQ_DEFAULT,
    parameter int DWELL_W = C_DWELL_W_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mod_n_sched_if.slave  bus
);
    localparam int                 PTR_W   = ptr_width(N_REQ);
    localparam logic [N_REQ-1:0]   C_ONE   = N_REQ'(1);
    localparam logic [DWELL_W-1:0] C_DW_1  = DWELL_W'(1);

    sched_state_e       state_q, state_d;
    logic [N_REQ-1:0]   mask_q,  mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] timer_q, timer_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q,  busy_d;

    logic               ptr_clr;
    logic               ptr_inc;
    logic [PTR_W-1:0]   ptr;
    logic               ptr_wrap;

    // Slot currently under the pointer is both enabled and requesting.
    logic               slot_hit;
    assign slot_hit = mask_q[ptr] & bus.req[ptr];

    slot_ptr_mod_n #(
        .N_REQ (N_REQ)
    ) u_slot_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (ptr_clr),
        .inc   (ptr_inc),
        .ptr   (ptr),
        .wrap  (ptr_wrap)
    );

    // FSM next-state, capture, dwell timer and grant decode.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        timer_d = timer_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        ptr_clr = 1'b0;
        ptr_inc = 1'b0;

        if (state_q != ST_IDLE && bus.stop) begin
            // Abort: no pointer step, so no frame marker either.
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            timer_d = '0;
            ptr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        mask_d  = bus.slot_mask;
                        dwell_d = (bus.dwell == '0) ? C_DW_1 : bus.dwell;
                        ptr_clr = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (slot_hit) begin
                        grant_d = C_ONE << ptr;
                        timer_d = dwell_q - C_DW_1;
                        state_d = ST_GRANT;
                    end else begin
                        ptr_inc = 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (timer_q == '0 || bus.slot_release || !bus.req[ptr]) begin
                        grant_d = '0;
                        state_d = ST_GAP;
                    end else begin
                        timer_d = timer_q - C_DW_1;
                    end
                end
                ST_GAP: begin
                    ptr_inc = 1'b1;
                    state_d = ST_SCAN;
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            dwell_q <= '0;
            timer_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = ptr;
    assign bus.busy       = busy_q;
    assign bus.frame_done = ptr_wrap;

endmodule : mod_n_slot_scheduler
`default_nettype wire

// File: tb/tb_mod_n_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_n_slot_scheduler
//  Description : Directed, table-driven bench for mod_n_slot_scheduler
//                (N_REQ=4, DWELL_W=8) plus frame-level sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_n_slot_scheduler;

    logic clk;
    logic reset;

    mod_n_sched_if #(.N_REQ(4), .DWELL_W(8)) bus ();

    mod_n_slot_scheduler #(.N_REQ(4), .DWELL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic [3:0] mask;
        logic [7:0] dwell;
        logic [3:0] req;
        logic       rel;
        logic [3:0] g;
        logic [1:0] id;
        logic       busy;
        logic       fd;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic rst, input logic start, input logic stop,
                       input logic [3:0] mask, input logic [7:0] dwell,
                       input logic [3:0] req, input logic rel,
                       input logic [3:0] g, input logic [1:0] id,
                       input logic busy, input logic fd);
        vec_t v;
        v.rst = rst; v.start = start; v.stop = stop; v.mask = mask;
        v.dwell = dwell; v.req = req; v.rel = rel;
        v.g = g; v.id = id; v.busy = busy; v.fd = fd;
        vecs.push_back(v);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic start, input logic stop,
                         input logic [3:0] mask, input logic [7:0] dwell,
                         input logic [3:0] req, input logic rel);
        reset            = rst;
        bus.start        = start;
        bus.stop         = stop;
        bus.slot_mask    = mask;
        bus.dwell        = dwell;
        bus.req          = req;
        bus.slot_release = rel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_fd, second_fd, gcount, bad, fdcount, gnz, notbusy;

        drive(1'b1, 1'b0, 1'b0, 4'b0000, 8'd0, 4'b0000, 1'b0);

        // --- 1: dwell=3, all slots; later mask/dwell changes are ignored
        add(1,0,0,4'b0000,8'd0,4'b0000,0, 4'b0000,2'd0,0,0);
        add(0,1,0,4'b1111,8'd3,4'b1111,0, 4'b0000,2'd0,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0001,2'd0,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0001,2'd0,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0001,2'd0,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd0,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0010,2'd1,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0010,2'd1,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0010,2'd1,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd2,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0100,2'd2,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0100,2'd2,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0100,2'd2,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd2,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd3,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b1000,2'd3,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b1000,2'd3,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b1000,2'd3,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd3,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd0,1,1);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0001,2'd0,1,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0001,2'd0,1,0);
        // --- 4: stop on the 2nd grant cycle
        add(0,0,1,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd0,0,0);
        add(0,0,0,4'b0000,8'd1,4'b1111,0, 4'b0000,2'd0,0,0);
        // --- 2: mask=1010, dwell=2; start while busy is ignored
        add(0,1,0,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd0,1,0);
        add(0,1,0,4'b1111,8'd2,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0010,2'd1,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0010,2'd1,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd2,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd3,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b1000,2'd3,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b1000,2'd3,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd3,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd0,1,1);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b1010,8'd2,4'b1111,0, 4'b0010,2'd1,1,0);
        add(0,0,1,4'b1010,8'd2,4'b1111,0, 4'b0000,2'd0,0,0);
        // --- 3: dwell=5, release on 2nd grant cycle; then request drop
        add(0,1,0,4'b1111,8'd5,4'b1111,0, 4'b0000,2'd0,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1111,0, 4'b0001,2'd0,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1111,0, 4'b0001,2'd0,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1111,1, 4'b0000,2'd0,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1111,0, 4'b0010,2'd1,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1101,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1101,0, 4'b0000,2'd2,1,0);
        add(0,0,0,4'b1111,8'd5,4'b1101,0, 4'b0100,2'd2,1,0);
        add(0,0,1,4'b1111,8'd5,4'b1101,0, 4'b0000,2'd0,0,0);
        // --- 5: dwell=0, mask=0000: pure scanning
        add(0,1,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd0,1,0);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd2,1,0);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd3,1,0);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd0,1,1);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd2,1,0);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd3,1,0);
        add(0,0,0,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd0,1,1);
        add(0,0,1,4'b0000,8'd0,4'b1111,0, 4'b0000,2'd0,0,0);
        // --- 6: start+stop together in IDLE
        add(0,1,1,4'b1111,8'd3,4'b1111,0, 4'b0000,2'd0,0,0);
        add(0,0,0,4'b1111,8'd3,4'b1111,0, 4'b0000,2'd0,0,0);
        // dwell=0 with all slots: one-cycle grant; release coincides with timer==0
        add(0,1,0,4'b1111,8'd0,4'b1111,1, 4'b0000,2'd0,1,0);
        add(0,0,0,4'b1111,8'd0,4'b1111,1, 4'b0001,2'd0,1,0);
        add(0,0,0,4'b1111,8'd0,4'b1111,1, 4'b0000,2'd0,1,0);
        add(0,0,0,4'b1111,8'd0,4'b1111,0, 4'b0000,2'd1,1,0);
        add(0,0,0,4'b1111,8'd0,4'b1111,0, 4'b0010,2'd1,1,0);
        // reset mid-GRANT, then reset wins over start
        add(1,0,0,4'b1111,8'd0,4'b1111,0, 4'b0000,2'd0,0,0);
        add(0,0,0,4'b1111,8'd0,4'b1111,0, 4'b0000,2'd0,0,0);
        add(1,1,0,4'b1111,8'd3,4'b1111,0, 4'b0000,2'd0,0,0);
        add(0,0,0,4'b1111,8'd3,4'b1111,0, 4'b0000,2'd0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].mask,
                  vecs[i].dwell, vecs[i].req, vecs[i].rel);
            cycle();
            checks++;
            if (bus.grant !== vecs[i].g || bus.grant_id !== vecs[i].id ||
                bus.busy !== vecs[i].busy || bus.frame_done !== vecs[i].fd) begin
                failures++;
                $display("FAIL vec%0d: got grant=%b id=%0d busy=%b fd=%b expected grant=%b id=%0d busy=%b fd=%b",
                         i, bus.grant, bus.grant_id, bus.busy, bus.frame_done,
                         vecs[i].g, vecs[i].id, vecs[i].busy, vecs[i].fd);
            end
        end

        // Full frame with dwell=3, all slots requesting: 20-cycle frame, 12 grant cycles.
        drive(0, 1, 0, 4'b1111, 8'd3, 4'b1111, 0);
        cycle();
        drive(0, 0, 0, 4'b1111, 8'd3, 4'b1111, 0);
        first_fd = -1; second_fd = -1; gcount = 0; bad = 0;
        for (int t = 0; t < 60; t++) begin
            if (bus.frame_done === 1'b1) begin
                if (first_fd < 0)       first_fd = t;
                else if (second_fd < 0) second_fd = t;
            end
            if (first_fd >= 0 && second_fd < 0 && bus.grant !== 4'b0000) gcount++;
            if (!$onehot0(bus.grant)) bad++;
            cycle();
        end
        check_int("frame_seen_twice", (second_fd >= 0) ? 1 : 0, 1);
        check_int("frame_period", second_fd - first_fd, 20);
        check_int("frame_grant_cycles", gcount, 12);
        check_int("grant_onehot", bad, 0);

        // Empty mask, dwell=0: frame marker every 4 cycles, never a grant.
        drive(0, 0, 1, 4'b0000, 8'd0, 4'b1111, 0);
        cycle();
        drive(0, 1, 0, 4'b0000, 8'd0, 4'b1111, 0);
        cycle();
        drive(0, 0, 0, 4'b0000, 8'd0, 4'b1111, 0);
        fdcount = 0; gnz = 0; notbusy = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (bus.frame_done === 1'b1) fdcount++;
            if (bus.grant !== 4'b0000)   gnz++;
            if (bus.busy !== 1'b1)       notbusy++;
        end
        check_int("empty_mask_frames", fdcount, 10);
        check_int("empty_mask_no_grant", gnz, 0);
        check_int("empty_mask_busy", notbusy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_n_slot_scheduler
`default_nettype wire
